vga_rx_decoder: RTL and testbench

VGA_RX_DECODER -- requirements
Module: vga_rx_decoder

---
 rtl/vga_rx_decoder.sv | 181 ++++++++++++++++++
 tb/tb_vga_rx_decoder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rx_decoder.sv
// VGA receiver: resynchronises hs/vs/rgb, measures line and frame periods, locks onto the
// expected timing and emits active-region pixels with their coordinates.
module vga_rx_decoder #(
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int H_DISP      = 640,
  parameter int H_TOTAL     = 800,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int V_DISP      = 480,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic [23:0] vga_rgb,
  output logic        pixel_valid,
  output logic [23:0] pixel_data,
  output logic [9:0]  pixel_xpos,
  output logic [9:0]  pixel_ypos,
  output logic        frame_start,
  output logic        locked,
  output logic [9:0]  h_total_meas,
  output logic [9:0]  v_total_meas
);

  localparam logic [9:0]  H_ACT_LO = 10'(H_SYNC + H_BACK);
  localparam logic [9:0]  H_ACT_HI = 10'(H_SYNC + H_BACK + H_DISP);
  localparam logic [9:0]  V_ACT_LO = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  V_ACT_HI = 10'(V_SYNC + V_BACK + V_DISP);
  localparam logic [10:0] H_TOT_L  = 11'(H_TOTAL);
  localparam logic [10:0] V_TOT_L  = 11'(V_TOTAL);
  localparam logic [3:0]  LOCK_N   = 4'(LOCK_FRAMES);
  localparam logic [9:0]  CNT_MAX  = 10'd1023;

  typedef enum logic [1:0] {SEARCH = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == CNT_MAX) ? v : v + 10'd1;
  endfunction

  logic        hs_r, hs_rr, vs_r, vs_rr;
  logic [23:0] rgb_r, rgb_rr;
  logic [9:0]  cnt_h, cnt_v;
  logic        vs_pend, h_meas_ok;
  logic        hs_fall, vs_fall, frame_bound, h_sat, v_sat;
  logic [10:0] h_period, v_period;
  logic        line_err, v_err;
  state_t      state, state_nxt;
  logic [3:0]  good_cnt, good_cnt_nxt, good_inc;
  logic        frame_err, frame_err_nxt;
  logic        h_act, v_act, pix_en;

  assign hs_fall     = ~hs_r & hs_rr;
  assign vs_fall     = ~vs_r & vs_rr;
  assign frame_bound = hs_fall & (vs_fall | vs_pend);
  assign h_sat       = (cnt_h == CNT_MAX);
  assign v_sat       = (cnt_v == CNT_MAX);
  assign h_period    = {1'b0, cnt_h} + 11'd1;
  assign v_period    = {1'b0, cnt_v} + 11'd1;
  // A line that ran into saturation (or the first after reset) carries no usable period.
  assign line_err    = hs_fall & h_meas_ok & ~h_sat & (h_period != H_TOT_L);
  assign v_err       = (v_period != V_TOT_L);
  assign good_inc    = good_cnt + 4'd1;

  // Input synchronisers and line/frame counters
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hs_r         <= 1'b1;
      hs_rr        <= 1'b1;
      vs_r         <= 1'b1;
      vs_rr        <= 1'b1;
      rgb_r        <= '0;
      rgb_rr       <= '0;
      cnt_h        <= '0;
      cnt_v        <= '0;
      vs_pend      <= 1'b0;
      h_meas_ok    <= 1'b0;
      h_total_meas <= '0;
      v_total_meas <= '0;
    end else begin
      hs_r   <= vga_hs;
      hs_rr  <= hs_r;
      vs_r   <= vga_vs;
      vs_rr  <= vs_r;
      rgb_r  <= vga_rgb;
      rgb_rr <= rgb_r;
      if (hs_fall) begin
        cnt_h     <= '0;
        h_meas_ok <= 1'b1;
        if (h_meas_ok && !h_sat) h_total_meas <= h_period[9:0];
      end else begin
        cnt_h <= sat_inc(cnt_h);
        if (h_sat) h_meas_ok <= 1'b0;
      end
      if (hs_fall)      vs_pend <= 1'b0;
      else if (vs_fall) vs_pend <= 1'b1;
      if (frame_bound) begin
        cnt_v        <= '0;
        v_total_meas <= v_period[9:0];
      end else if (hs_fall) begin
        cnt_v <= sat_inc(cnt_v);
      end
    end
  end

  // Lock FSM state register
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= SEARCH;
      good_cnt  <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      good_cnt  <= good_cnt_nxt;
      frame_err <= frame_err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    good_cnt_nxt  = good_cnt;
    frame_err_nxt = frame_err;
    case (state)
      SEARCH: begin
        if (frame_bound && !h_sat) begin
          state_nxt     = VERIFY;
          good_cnt_nxt  = '0;
          frame_err_nxt = 1'b0;
        end
      end
      VERIFY: begin
        if (h_sat) begin
          state_nxt = SEARCH;
        end else if (frame_bound) begin
          frame_err_nxt = 1'b0;
          if (frame_err || line_err || v_err) begin
            good_cnt_nxt = '0;
          end else if (good_inc >= LOCK_N) begin
            good_cnt_nxt = '0;
            state_nxt    = LOCKED;
          end else begin
            good_cnt_nxt = good_inc;
          end
        end else if (line_err) begin
          frame_err_nxt = 1'b1;
        end
      end
      LOCKED: begin
        if (h_sat || v_sat || line_err || (frame_bound && v_err)) state_nxt = SEARCH;
      end
      default: state_nxt = SEARCH;
    endcase
  end

  assign locked = (state == LOCKED);
  assign h_act  = (cnt_h >= H_ACT_LO) && (cnt_h < H_ACT_HI);
  assign v_act  = (cnt_v >= V_ACT_LO) && (cnt_v < V_ACT_HI);
  // Dropping lock this cycle also suppresses the pixel that revealed the timing fault.
  assign pix_en = h_act & v_act & (state == LOCKED) & (state_nxt == LOCKED);

  // Output register stage
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pixel_valid <= 1'b0;
      pixel_data  <= '0;
      pixel_xpos  <= '0;
      pixel_ypos  <= '0;
      frame_start <= 1'b0;
    end else begin
      pixel_valid <= pix_en;
      pixel_data  <= pix_en ? rgb_rr : 24'h0;
      pixel_xpos  <= pix_en ? (cnt_h - H_ACT_LO) : 10'h0;
      pixel_ypos  <= pix_en ? (cnt_v - V_ACT_LO) : 10'h0;
      frame_start <= pix_en && (cnt_h == H_ACT_LO) && (cnt_v == V_ACT_LO);
    end
  end

endmodule

// File: tb/tb_vga_rx_decoder.sv
// Directed bench for vga_rx_decoder using a scaled-down 20x10 timing (8x4 active area).
module tb_vga_rx_decoder;

  localparam int HS = 4, HB = 3, HD = 8, HT = 20;
  localparam int VS = 2, VB = 2, VD = 4, VT = 10;
  localparam int X0 = HS + HB;
  localparam int Y0 = VS + VB;

  logic        vga_clk;
  logic        sys_rst_n;
  logic        vga_hs, vga_vs;
  logic [23:0] vga_rgb;
  logic        pixel_valid;
  logic [23:0] pixel_data;
  logic [9:0]  pixel_xpos, pixel_ypos;
  logic        frame_start, locked;
  logic [9:0]  h_total_meas, v_total_meas;

  int n_checks = 0;
  int n_fail   = 0;
  int vld_total = 0, fs_total = 0, lock_total = 0, pix_err = 0, fs_err = 0;
  int last_x = 0, last_y = 0;
  int v0, f0, l0;
  logic [23:0] hist1 = '0, hist2 = '0;

  vga_rx_decoder #(
    .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_TOTAL(VT), .LOCK_FRAMES(2)
  ) dut (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_rgb(vga_rgb),
    .pixel_valid(pixel_valid), .pixel_data(pixel_data),
    .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
    .frame_start(frame_start), .locked(locked),
    .h_total_meas(h_total_meas), .v_total_meas(v_total_meas)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_pins(input int ln, input int c);
    vga_hs = (c < HS) ? 1'b0 : 1'b1;
    vga_vs = (ln < VS) ? 1'b0 : 1'b1;
    if (c >= X0 && c < X0 + HD && ln >= Y0 && ln < Y0 + VD)
      vga_rgb = {4'h0, 10'(c - X0), 10'(ln - Y0)};
    else
      vga_rgb = 24'h5A5A5A;
  endtask

  task automatic drive_line(input int ln, input int len);
    for (int c = 0; c < len; c++) begin
      @(negedge vga_clk);
      set_pins(ln, c);
    end
  endtask

  task automatic drive_frame(input int nlines, input int bad_ln, input int bad_len);
    for (int ln = 0; ln < nlines; ln++)
      drive_line(ln, (ln == bad_ln) ? bad_len : HT);
  endtask

  // Output monitor: 3-edge latency against pin history, coordinate/colour agreement, idle zeros.
  always @(posedge vga_clk) begin
    #1;
    if (pixel_valid) begin
      vld_total++;
      if (pixel_data !== {4'h0, pixel_xpos, pixel_ypos}) pix_err++;
      if (pixel_data !== hist2) pix_err++;
      if (((pixel_xpos == 10'd0) && (pixel_ypos == 10'd0)) != frame_start) fs_err++;
      last_x = int'(pixel_xpos);
      last_y = int'(pixel_ypos);
    end else if (pixel_data !== 24'h0 || pixel_xpos !== 10'h0 || pixel_ypos !== 10'h0 ||
                 frame_start !== 1'b0) begin
      pix_err++;
    end
    if (frame_start) fs_total++;
    if (locked) lock_total++;
    hist2 = hist1;
    hist1 = vga_rgb;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_n = 1'b0;
    vga_hs = 1'b1;
    vga_vs = 1'b1;
    vga_rgb = 24'h0;
    repeat (3) @(negedge vga_clk);
    check_val("rst_valid", 32'(pixel_valid), 32'd0);
    check_val("rst_data", 32'(pixel_data), 32'd0);
    check_val("rst_locked", 32'(locked), 32'd0);
    check_val("rst_hmeas", 32'(h_total_meas), 32'd0);
    check_val("rst_vmeas", 32'(v_total_meas), 32'd0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge vga_clk);

    // Lock acquisition from reset
    v0 = vld_total;
    drive_frame(VT, -1, 0);
    drive_frame(VT, -1, 0);
    check_val("lock_early", 32'(locked), 32'd0);
    check_val("vld_unlocked", 32'(vld_total - v0), 32'd0);
    v0 = vld_total; f0 = fs_total;
    drive_frame(VT, -1, 0);
    check_val("lock_third", 32'(locked), 32'd1);
    check_val("vld_frame", 32'(vld_total - v0), 32'(HD * VD));
    check_val("fs_frame", 32'(fs_total - f0), 32'd1);
    check_val("last_x", 32'(last_x), 32'(HD - 1));
    check_val("last_y", 32'(last_y), 32'(VD - 1));
    check_val("hmeas", 32'(h_total_meas), 32'(HT));
    check_val("vmeas", 32'(v_total_meas), 32'(VT));
    v0 = vld_total; f0 = fs_total;
    drive_frame(VT, -1, 0);
    check_val("vld_frame4", 32'(vld_total - v0), 32'(HD * VD));
    check_val("fs_frame4", 32'(fs_total - f0), 32'd1);

    // One line one clock short while locked
    v0 = vld_total;
    for (int ln = 0; ln < 5; ln++) drive_line(ln, HT);
    drive_line(5, HT - 1);
    check_val("lock_pre_short", 32'(locked), 32'd1);
    drive_line(6, HT);
    check_val("lock_short", 32'(locked), 32'd0);
    check_val("hmeas_short", 32'(h_total_meas), 32'(HT - 1));
    for (int ln = 7; ln < VT; ln++) drive_line(ln, HT);
    check_val("vld_short", 32'(vld_total - v0), 32'(2 * HD));
    drive_frame(VT, -1, 0);
    drive_frame(VT, -1, 0);
    check_val("relock_early", 32'(locked), 32'd0);
    v0 = vld_total;
    drive_frame(VT, -1, 0);
    check_val("relock", 32'(locked), 32'd1);
    check_val("vld_relock", 32'(vld_total - v0), 32'(HD * VD));
    check_val("hmeas_relock", 32'(h_total_meas), 32'(HT));

    // Line cut off inside the active region
    v0 = vld_total;
    drive_frame(VT, 5, 12);
    check_val("vld_trunc", 32'(vld_total - v0), 32'(HD + 4));
    check_val("trunc_last_x", 32'(last_x), 32'd3);
    check_val("trunc_last_y", 32'(last_y), 32'd1);
    check_val("lock_trunc", 32'(locked), 32'd0);
    repeat (3) drive_frame(VT, -1, 0);
    check_val("relock_trunc", 32'(locked), 32'd1);

    // Missing hsync long enough to saturate the line counter
    drive_frame(VT, -1, 0);
    repeat (1100) begin
      @(negedge vga_clk);
      vga_hs = 1'b1;
      vga_vs = 1'b1;
      vga_rgb = 24'h5A5A5A;
    end
    check_val("lock_sat", 32'(locked), 32'd0);
    check_val("valid_sat", 32'(pixel_valid), 32'd0);
    check_val("hmeas_sat", 32'(h_total_meas), 32'(HT));
    drive_line(0, HT);
    check_val("hmeas_after_sat", 32'(h_total_meas), 32'(HT));
    for (int ln = 1; ln < VT; ln++) drive_line(ln, HT);
    repeat (3) drive_frame(VT, -1, 0);
    check_val("relock_sat", 32'(locked), 32'd1);

    // Asynchronous reset in the middle of an active line
    for (int ln = 0; ln < 6; ln++) drive_line(ln, HT);
    drive_line(6, 12);
    check_val("valid_pre_rst", 32'(pixel_valid), 32'd1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check_val("arst_valid", 32'(pixel_valid), 32'd0);
    check_val("arst_data", 32'(pixel_data), 32'd0);
    check_val("arst_xpos", 32'(pixel_xpos), 32'd0);
    check_val("arst_ypos", 32'(pixel_ypos), 32'd0);
    check_val("arst_locked", 32'(locked), 32'd0);
    check_val("arst_hmeas", 32'(h_total_meas), 32'd0);
    check_val("arst_vmeas", 32'(v_total_meas), 32'd0);
    for (int c = 12; c < HT; c++) begin
      @(negedge vga_clk);
      if (c == 14) sys_rst_n = 1'b1;
      set_pins(6, c);
    end
    for (int ln = 7; ln < VT; ln++) drive_line(ln, HT);
    drive_frame(VT, -1, 0);
    drive_frame(VT, -1, 0);
    check_val("relock_rst_early", 32'(locked), 32'd0);
    v0 = vld_total;
    drive_frame(VT, -1, 0);
    check_val("relock_rst", 32'(locked), 32'd1);
    check_val("vld_relock_rst", 32'(vld_total - v0), 32'(HD * VD));

    // Frames one line too long never lock
    @(negedge vga_clk);
    sys_rst_n = 1'b0;
    @(negedge vga_clk);
    sys_rst_n = 1'b1;
    l0 = lock_total;
    repeat (4) drive_frame(VT + 1, -1, 0);
    check_val("long_never_locked", 32'(lock_total - l0), 32'd0);
    check_val("long_vmeas", 32'(v_total_meas), 32'(VT + 1));
    check_val("long_hmeas", 32'(h_total_meas), 32'(HT));

    repeat (4) @(negedge vga_clk);
    check_val("pix_stream", 32'(pix_err), 32'd0);
    check_val("fs_stream", 32'(fs_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
